// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_adder_pkg;

  // FSM state encoding: 2 bits.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SA_W_DEFAULT = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full-adder cell, purely combinational.
// Latency: 0 cycles.
// Backpressure: none.
// Ports: a, b, ci -> s (sum bit), co (carry out).
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one fa cell per clock, LSB first, {cout,sum} = a + b + cin.
// Latency: done pulses W cycles after the edge that accepts start; one result per W+1 cycles.
// Backpressure: start is only taken in IDLE or DONE; it is ignored while busy.
// Ports: ck, rst_n (async, active-low), start, a, b, cin in; busy, done, sum, cout out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = SA_W_DEFAULT
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int                CNT_W = $clog2(W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(W - 1);

  state_t           state;
  logic [W-1:0]     a_sr;
  logic [W-1:0]     b_sr;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;

  // cout is the carry flip-flop itself, so it feeds the cell between bits.
  fa u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (cout),
    .s  (fa_s),
    .co (fa_co)
  );

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            a_sr  <= a;
            b_sr  <= b;
            cout  <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          // New sum bit enters at the MSB; after W shifts bit 0 sits at the LSB.
          sum  <= {fa_s, sum[W-1:1]};
          cout <= fa_co;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b0;
          // Accepting start here keeps back-to-back throughput at W+1 cycles.
          if (start) begin
            state <= RUN;
            a_sr  <= a;
            b_sr  <= b;
            cout  <= cin;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial W-bit adder built around the single-bit full-adder cell `fa`. It sits directly downstream of that cell: it streams operand bits LSB-first through one `fa` instance per clock and holds the carry between bits in a flip-flop. It assembles the sum in a shift register and reports completion with a one-cycle `done` pulse. It is the area-minimal adder for the shuttle datapath, trading W cycles of latency for one full-adder cell.

## Interface
- `W`, default 8: operand and sum width; legal range is W ≥ 2.
- `ck`, input, 1: the single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous reset, active-low.
- `start`, input, 1: request a new addition; sampled on the rising edge of `ck`.
- `a`, input, W: operand A; captured when `start` is accepted.
- `b`, input, W: operand B; captured when `start` is accepted.
- `cin`, input, 1: carry-in; captured when `start` is accepted.
- `busy`, output, 1: high while an addition is in progress.
- `done`, output, 1: one-cycle pulse; `sum` and `cout` are valid.
- `sum`, output, W: result; held stable from `done` until the next accepted `start`.
- `cout`, output, 1: carry-out; held stable on the same terms as `sum`.

## Operation
- States:
  - IDLE → RUN, on `start`. The block loads `a` and `b` into the operand shift registers, loads `cin` into the carry flip-flop, and clears the bit counter.
  - RUN → RUN, while the counter is below W-1. On every edge:
    - Operand LSBs and the carry feed `fa`.
    - `fa.s` shifts into the sum register at the MSB, so after W shifts bit 0 is at the LSB.
    - `fa.co` loads the carry flip-flop.
    - Both operand registers shift right.
    - The counter increments.
  - RUN → DONE, on the edge that processes bit W-1.
  - DONE → RUN, if `start` is high (back-to-back operation is allowed).
  - DONE → IDLE, otherwise.
- `start` is ignored in RUN. It does not restart the operation, and it does not recapture operands.
- `cout` is the carry flip-flop. It is valid whenever `done` is high and is held afterwards.
- The result is `{cout,sum} = a + b + cin`, computed modulo 2^(W+1). No overflow flag is produced.
- Counter width is $clog2(W).

## Timing
- Reset (async assert, `ck`-synchronous deassert handled upstream):
  - State goes to IDLE.
  - `busy`, `done`, `sum`, `cout`, the counter and the operand registers all go to 0.
- Latency, where edge 0 is the edge that samples `start` in IDLE or DONE:
  - `busy` is high from edge 0 through edge W.
  - Bits 0 to W-1 are processed on edges 1 to W.
  - `done` is high for exactly one cycle, from edge W to edge W+1.
  - `busy` is low while `done` is high.
- Throughput is one addition per W+1 cycles, including the back-to-back case, since `start` is taken in DONE.
- `done` and `busy` are registered state decodes and never glitch.
- If reset asserts mid-RUN, the operation is abandoned immediately. After reset releases, `done` is not asserted and all outputs read 0.
- If `start` is held high continuously, the block runs back-to-back operations and recaptures `a`, `b` and `cin` at each DONE.

## Structure
- A shared package `serial_adder_pkg` holds:
  - the state enum (IDLE, RUN, DONE) with 2-bit encoding;
  - the default width constant `SA_W_DEFAULT = 8`.
- The single sub-module is `fa` (ports a, b, ci, s, co), instantiated once, purely combinational. The surrounding registers and the FSM live in `serial_adder`.

## Test plan
- Reset, then with W=8: `a=0x00, b=0x00, cin=0`, pulse `start` → exactly 8 cycles later `done`=1 for one cycle, `sum=0x00`, `cout=0`.
- `a=0xFF, b=0x01, cin=0` → `sum=0x00`, `cout=1`. Then `a=0xA5, b=0x5A, cin=1` → `sum=0x00`, `cout=1`. Then `a=0x3C, b=0x42, cin=0` → `sum=0x7E`, `cout=0`.
- Start `a=0x10, b=0x20`, then pulse `start` with `a=0xFF, b=0xFF` during RUN → `done` at the original time with `sum=0x30`; the second request is ignored.
- Hold `start` high with a new operand pair each DONE → results appear every 9 cycles, each correct, with no idle cycle between operations.
- Assert `rst_n` low at cycle 4 of RUN → all outputs are 0 immediately. After release there is no `done` until a new `start`, and the next addition is correct.
- Exhaustive run with W=3: all 128 `{a,b,cin}` combinations → `{cout,sum}` equals the arithmetic sum in every case. This also exercises every row of the `fa` truth table.
